// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encodings and parity modes.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, reset to 1 (idle line).
module sync_2ff (
  input  logic i_Clock,
  input  logic i_Rst_n,
  input  logic i_D,
  output logic o_Q
);

  logic meta;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      meta <= 1'b1;
      o_Q  <= 1'b1;
    end else begin
      meta <= i_D;
      o_Q  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: start/data/optional parity/1-2 stop bits, mid-bit sampling.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 i_Rx_Serial,
  output logic [DATA_BITS-1:0] o_Rx_Data,
  output logic                 o_Rx_Valid,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic             HAS_PAR  = (PARITY_MODE != PARITY_NONE);
  localparam logic             PAR_ODD  = (PARITY_MODE == PARITY_ODD);

  uart_state_t          state;
  logic [CNT_W-1:0]     clk_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] data_sh;
  logic                 par_err_r;
  logic                 stop_err_r;
  logic                 rx_sync;

  sync_2ff u_sync (
    .i_Clock (i_Clock),
    .i_Rst_n (i_Rst_n),
    .i_D     (i_Rx_Serial),
    .o_Q     (rx_sync)
  );

  assign o_Busy = (state != ST_IDLE);

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state        <= ST_IDLE;
      clk_cnt      <= '0;
      bit_cnt      <= '0;
      data_sh      <= '0;
      par_err_r    <= 1'b0;
      stop_err_r   <= 1'b0;
      o_Rx_Data    <= '0;
      o_Rx_Valid   <= 1'b0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
    end else begin
      o_Rx_Valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          clk_cnt    <= '0;
          bit_cnt    <= '0;
          par_err_r  <= 1'b0;
          stop_err_r <= 1'b0;
          if (!rx_sync) state <= ST_START;
        end
        ST_START: begin
          if (clk_cnt == CNT_HALF) begin
            clk_cnt <= '0;
            state   <= rx_sync ? ST_IDLE : ST_DATA;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            // LSB arrives first, so shifting right lands sample N at bit index N
            data_sh <= {rx_sync, data_sh[DATA_BITS-1:1]};
            if (bit_cnt == 4'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= HAS_PAR ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        ST_PARITY: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt   <= '0;
            par_err_r <= (^data_sh) ^ rx_sync ^ PAR_ODD;
            state     <= ST_STOP;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            if (bit_cnt == 4'(STOP_BITS - 1)) begin
              // Leave at mid-stop so a start edge in the second half is caught
              o_Rx_Data    <= data_sh;
              o_Rx_Valid   <= 1'b1;
              o_Parity_Err <= par_err_r;
              o_Frame_Err  <= stop_err_r | ~rx_sync;
              bit_cnt      <= '0;
              state        <= ST_IDLE;
            end else begin
              stop_err_r <= stop_err_r | ~rx_sync;
              bit_cnt    <= bit_cnt + 4'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
